// File: rtl/sm_trace_pkg.sv
// Shared definitions for the schoolMIPS retire-trace transmitter.
// The package holds the record layout, the header field positions and the
// helper function that builds the header word.
package sm_trace_pkg;

    localparam logic [7:0] TRACE_SYNC   = 8'hA5;
    localparam int         TRACE_WORDS  = 4;
    localparam int         TRACE_DROP_W = 7;

    // Header word layout: {sync[31:24], we[23], drop[22:16], stamp[15:0]}
    localparam int HDR_SYNC_LSB  = 24;
    localparam int HDR_WE_BIT    = 23;
    localparam int HDR_DROP_LSB  = 16;
    localparam int HDR_STAMP_LSB = 0;

    typedef struct packed {
        logic [15:0]             stamp;
        logic [TRACE_DROP_W-1:0] drop;
        logic                    we;
        logic [31:0]             pc;
        logic [31:0]             instr;
        logic [31:0]             wdata;
    } trace_rec_t;

    // Build word 0 of a record from its stored fields.
    function automatic logic [31:0] traceHeader(input trace_rec_t rec);
        logic [31:0] hdr;
        hdr                                  = 32'h0;
        hdr[HDR_SYNC_LSB +: 8]               = TRACE_SYNC;
        hdr[HDR_WE_BIT]                      = rec.we;
        hdr[HDR_DROP_LSB +: TRACE_DROP_W]    = rec.drop;
        hdr[HDR_STAMP_LSB +: 16]             = rec.stamp;
        return hdr;
    endfunction

endpackage

// File: rtl/sm_trace_fifo.sv
// Synchronous record FIFO for the trace transmitter.
// Pointers carry one extra MSB so full and empty are told apart without a
// separate flag. A push is accepted while full when a pop happens in the
// same cycle; the caller guarantees that, and that pop only happens when
// the FIFO is not empty. rst_n is an asynchronous, active-high reset.
module sm_trace_fifo
    import sm_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  trace_rec_t             wrData,
    output trace_rec_t             rdData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};

    trace_rec_t  mem [DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;

    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign empty  = (wrPtr == rdPtr);
    assign rdData = mem[rdPtr[AW-1:0]];

    // Advance read/write pointers and track the occupancy count.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + PTR_ONE;
                2'b01:   level <= level - PTR_ONE;
                default: level <= level;
            endcase
        end
    end

    // Record storage; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/sm_trace_tx.sv
// Retire-trace transmitter for the schoolMIPS pipeline.
// Every W-stage retirement (while trace_en is set) becomes a 4-word record
// in a FIFO; records leave over a 32-bit valid/ready stream, one word per
// handshake. When the FIFO is full the record is dropped and counted, and
// the count rides in the header of the next record that gets in.
// rst_n is an asynchronous, active-high reset despite its name.
module sm_trace_tx
    import sm_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trace_en,
    input  logic                   ret_valid,
    input  logic [31:0]            ret_pc,
    input  logic [31:0]            ret_instr,
    input  logic                   ret_we,
    input  logic [31:0]            ret_wdata,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [31:0]            tx_data,
    output logic                   tx_last,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
);

    localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE  = {{(DROP_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        LAST_WORD = 2'(TRACE_WORDS - 1);

    logic              fifoFull;
    logic              fifoEmpty;
    logic              pushRec;
    logic              popRec;
    logic              dropRec;
    logic              handshake;
    logic [1:0]        wordIdx;
    logic [15:0]       stampCnt;
    logic [DROP_W-1:0] dropCnt;
    trace_rec_t        capRec;
    trace_rec_t        headRec;

    assign tx_valid  = !fifoEmpty;
    assign tx_last   = tx_valid & (wordIdx == LAST_WORD);
    assign handshake = tx_valid & tx_ready;
    // The head record leaves on the handshake of its last word.
    assign popRec    = handshake & (wordIdx == LAST_WORD);
    // A departing record frees a slot in the same cycle, so full+pop captures.
    assign pushRec   = trace_en & ret_valid & (!fifoFull | popRec);
    assign dropRec   = trace_en & ret_valid & fifoFull & !popRec;

    // Assemble the record for the retiring instruction.
    always_comb begin
        capRec       = '0;
        capRec.stamp = stampCnt;
        capRec.drop  = TRACE_DROP_W'(dropCnt);
        capRec.we    = ret_we;
        capRec.pc    = ret_pc;
        capRec.instr = ret_instr;
        if (ret_we) begin
            capRec.wdata = ret_wdata;
        end else begin
            capRec.wdata = 32'h0;
        end
    end

    sm_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (pushRec),
        .pop    (popRec),
        .wrData (capRec),
        .rdData (headRec),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .level  (level)
    );

    // Free-running cycle stamp, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stampCnt <= 16'h0;
        end else begin
            stampCnt <= stampCnt + 16'd1;
        end
    end

    // Saturating drop count, cleared once handed to a captured record; sticky ovf.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dropCnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (pushRec) begin
                dropCnt <= '0;
            end else if (dropRec && (dropCnt != DROP_MAX)) begin
                dropCnt <= dropCnt + DROP_ONE;
            end
            if (dropRec) begin
                ovf <= 1'b1;
            end
        end
    end

    // Word index within the head record, stepping on each accepted word.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wordIdx <= 2'd0;
        end else if (handshake) begin
            wordIdx <= wordIdx + 2'd1;
        end
    end

    // Select the head record word currently on the stream.
    always_comb begin
        case (wordIdx)
            2'd0:    tx_data = traceHeader(headRec);
            2'd1:    tx_data = headRec.pc;
            2'd2:    tx_data = headRec.instr;
            2'd3:    tx_data = headRec.wdata;
            default: tx_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_sm_trace_tx.sv
// Self-checking bench for sm_trace_tx. A negedge monitor keeps a
// transaction-level model (occupancy, word index, drop count, stamp) and a
// queue of expected stream words; scenario tasks add their own direct checks.
module tb_sm_trace_tx;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trace_en;
    logic          ret_valid;
    logic [31:0]   ret_pc;
    logic [31:0]   ret_instr;
    logic          ret_we;
    logic [31:0]   ret_wdata;
    logic          tx_valid;
    logic          tx_ready;
    logic [31:0]   tx_data;
    logic          tx_last;
    logic          ovf;
    logic [LW-1:0] level;

    int vecCount = 0;
    int errCount = 0;

    logic [31:0] expQ[$];
    int          mLevel;
    int          mIdx;
    logic [6:0]  mDrop;
    logic        mOvf;
    logic [15:0] mStamp;
    logic        mValid, mHs, mPop, mCap, mDropEv;
    logic [LW-1:0] mLevelW;

    sm_trace_tx #(.DEPTH(DEPTH), .DROP_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trace_en  (trace_en),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_instr (ret_instr),
        .ret_we    (ret_we),
        .ret_wdata (ret_wdata),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .ovf       (ovf),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: inputs are driven 1 time unit after posedge, so at
    // negedge they are what the DUT will see at the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            expQ.delete();
            mLevel = 0; mIdx = 0; mDrop = 7'd0; mOvf = 1'b0; mStamp = 16'h0;
        end else begin
            mValid  = (mLevel != 0);
            mLevelW = mLevel[LW-1:0];
            vecCount++;
            if (tx_valid !== mValid) begin
                errCount++; $display("FAIL mon_valid: got %b want %b at %0t", tx_valid, mValid, $time);
            end
            vecCount++;
            if (tx_last !== (mValid && mIdx == 3)) begin
                errCount++; $display("FAIL mon_last: got %b want %b at %0t", tx_last, (mValid && mIdx == 3), $time);
            end
            vecCount++;
            if (level !== mLevelW) begin
                errCount++; $display("FAIL mon_level: got %0d want %0d at %0t", level, mLevelW, $time);
            end
            vecCount++;
            if (ovf !== mOvf) begin
                errCount++; $display("FAIL mon_ovf: got %b want %b at %0t", ovf, mOvf, $time);
            end
            mHs  = mValid && tx_ready;
            mPop = mHs && (mIdx == 3);
            if (mHs) begin
                vecCount++;
                if (expQ.size() == 0) begin
                    errCount++; $display("FAIL mon_data: got %h want <no word queued> at %0t", tx_data, $time);
                end else begin
                    if (tx_data !== expQ[0]) begin
                        errCount++; $display("FAIL mon_data: got %h want %h at %0t", tx_data, expQ[0], $time);
                    end
                    void'(expQ.pop_front());
                end
                mIdx = (mIdx + 1) % 4;
            end
            mCap    = trace_en && ret_valid && ((mLevel < DEPTH) || mPop);
            mDropEv = trace_en && ret_valid && (mLevel == DEPTH) && !mPop;
            if (mCap) begin
                expQ.push_back({8'hA5, ret_we, mDrop, mStamp});
                expQ.push_back(ret_pc);
                expQ.push_back(ret_instr);
                expQ.push_back(ret_we ? ret_wdata : 32'h0);
                mDrop = 7'd0;
            end
            if (mDropEv) begin
                if (mDrop != 7'h7F) mDrop = mDrop + 7'd1;
                mOvf = 1'b1;
            end
            if (mCap && !mPop) mLevel++;
            else if (mPop && !mCap) mLevel--;
            mStamp = mStamp + 16'd1;
        end
    end

    task automatic doReset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                          input logic we, input logic [31:0] wdata);
        ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_we = we; ret_wdata = wdata;
        @(posedge clk); #1;
        ret_valid = 1'b0;
    endtask

    task automatic test_reset();
        trace_en = 1'b1; ret_valid = 1'b0; tx_ready = 1'b0;
        doReset();
        vecCount++; if (tx_valid !== 1'b0) begin errCount++; $display("FAIL rst_valid: got %b want 0", tx_valid); end
        vecCount++; if (tx_last !== 1'b0) begin errCount++; $display("FAIL rst_last: got %b want 0", tx_last); end
        vecCount++; if (level !== 4'd0) begin errCount++; $display("FAIL rst_level: got %0d want 0", level); end
        vecCount++; if (ovf !== 1'b0) begin errCount++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        trace_en = 1'b0; ret_valid = 1'b1; ret_pc = 32'h10; ret_instr = 32'h1; ret_we = 1'b0;
        repeat (3) @(posedge clk);
        #1; ret_valid = 1'b0; trace_en = 1'b1;
        vecCount++; if (level !== 4'd0) begin errCount++; $display("FAIL trace_off_level: got %0d want 0", level); end
    endtask

    task automatic test_single();
        logic [31:0] exp [4];
        exp = '{32'hA5800010, 32'h00000040, 32'h24010005, 32'h00000005};
        doReset();
        tx_ready = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        retire(32'h40, 32'h24010005, 1'b1, 32'h5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecCount++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i] || tx_last !== (i == 3)) begin
                errCount++;
                $display("FAIL single_w%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, tx_valid, tx_data, tx_last, exp[i], (i == 3));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        vecCount++; if (tx_valid !== 1'b0) begin errCount++; $display("FAIL single_idle: got %b want 0", tx_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [3];
        exp = '{32'h00000100, 32'h8C020004, 32'hDEADBEEF};
        tx_ready = 1'b0;
        retire(32'h100, 32'h8C020004, 1'b1, 32'hDEADBEEF);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vecCount++;
            if (tx_valid !== 1'b1 || tx_data !== 32'h100 || tx_last !== 1'b0) begin
                errCount++;
                $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want v=1 d=00000100 l=0", i, tx_valid, tx_data, tx_last);
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecCount++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                errCount++; $display("FAIL bp_w%0d: got v=%b d=%h want v=1 d=%h", i + 1, tx_valid, tx_data, exp[i]);
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int n;
        doReset();
        tx_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            retire(32'h400 + 32'(i * 4), 32'h20000000 + 32'(i), 1'b1, 32'(i));
        end
        vecCount++; if (level !== 4'd8) begin errCount++; $display("FAIL ovf_level: got %0d want 8", level); end
        vecCount++; if (ovf !== 1'b1) begin errCount++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        tx_ready = 1'b1;
        n = 0;
        while (level != 4'd0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        vecCount++; if (level !== 4'd0) begin errCount++; $display("FAIL ovf_drain: got level %0d want 0 after %0d clk", level, n); end
        tx_ready = 1'b0;
        retire(32'h800, 32'h11111111, 1'b0, 32'h0);
        retire(32'h804, 32'h22222222, 1'b0, 32'h0);
        @(negedge clk);
        vecCount++; if (tx_data[22:16] !== 7'd3) begin errCount++; $display("FAIL ovf_drop3: got %0d want 3", tx_data[22:16]); end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1; tx_ready = 1'b0;
        @(negedge clk);
        vecCount++; if (tx_data[22:16] !== 7'd0) begin errCount++; $display("FAIL ovf_drop0: got %0d want 0", tx_data[22:16]); end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1; tx_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        doReset();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            retire(32'h600 + 32'(i * 4), 32'h30000000 + 32'(i), 1'b1, 32'hA0 + 32'(i));
        end
        vecCount++; if (level !== 4'd8) begin errCount++; $display("FAIL fp_full: got %0d want 8", level); end
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ret_valid = 1'b1; ret_pc = 32'h900; ret_instr = 32'h3C010900; ret_we = 1'b1; ret_wdata = 32'h900;
        @(negedge clk);
        vecCount++; if (tx_last !== 1'b1) begin errCount++; $display("FAIL fp_last: got %b want 1", tx_last); end
        @(posedge clk); #1;
        ret_valid = 1'b0; tx_ready = 1'b0;
        vecCount++; if (level !== 4'd8) begin errCount++; $display("FAIL fp_level: got %0d want 8", level); end
        vecCount++; if (ovf !== 1'b0) begin errCount++; $display("FAIL fp_ovf: got %b want 0", ovf); end
        tx_ready = 1'b1;
        repeat (32) @(posedge clk);
        #1; tx_ready = 1'b0;
        vecCount++; if (level !== 4'd0) begin errCount++; $display("FAIL fp_drain: got %0d want 0", level); end
    endtask

    task automatic test_back_to_back();
        tx_ready = 1'b0;
        retire(32'hA00, 32'h01000001, 1'b1, 32'hCAFEF00D);
        retire(32'hA04, 32'hAC000004, 1'b0, 32'h12345678);
        retire(32'hA08, 32'h02000002, 1'b1, 32'h0000FFFF);
        tx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vecCount++;
            if (tx_valid !== 1'b1 || tx_last !== ((i % 4) == 3)) begin
                errCount++; $display("FAIL b2b_w%0d: got v=%b l=%b want v=1 l=%b", i, tx_valid, tx_last, ((i % 4) == 3));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        vecCount++; if (tx_valid !== 1'b0) begin errCount++; $display("FAIL b2b_idle: got %b want 0", tx_valid); end
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            retire(32'hC00 + 32'(i * 4), 32'h40000000 + 32'(i), 1'b1, 32'(i));
        end
        vecCount++; if (ovf !== 1'b1) begin errCount++; $display("FAIL rm_ovf_pre: got %b want 1", ovf); end
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1; tx_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        vecCount++; if (tx_valid !== 1'b0) begin errCount++; $display("FAIL rm_valid: got %b want 0", tx_valid); end
        vecCount++; if (level !== 4'd0) begin errCount++; $display("FAIL rm_level: got %0d want 0", level); end
        vecCount++; if (ovf !== 1'b0) begin errCount++; $display("FAIL rm_ovf: got %b want 0", ovf); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        retire(32'h2000, 32'h00000000, 1'b0, 32'hFFFFFFFF);
        @(negedge clk);
        vecCount++;
        if (tx_valid !== 1'b1 || tx_data !== 32'hA5000005 || tx_last !== 1'b0) begin
            errCount++; $display("FAIL rm_restart: got v=%b d=%h l=%b want v=1 d=a5000005 l=0", tx_valid, tx_data, tx_last);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1; tx_ready = 1'b0;
        @(negedge clk);
        vecCount++; if (tx_valid !== 1'b0) begin errCount++; $display("FAIL rm_idle: got %b want 0", tx_valid); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1; trace_en = 1'b1; ret_valid = 1'b0; ret_pc = 32'h0; ret_instr = 32'h0;
        ret_we = 1'b0; ret_wdata = 32'h0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
